// File: rtl/iter_shift_unit_pkg.sv
// Shared op codes and FSM states for the iterative shift/rotate unit.
// Also consumed by the ALU opSelect decode.
package iter_shift_unit_pkg;

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic logic is_shift_op(input logic [2:0] op);
        return op <= OP_ROL;
    endfunction

endpackage

// File: rtl/iter_shift_unit_step.sv
// One combinational shift/rotate step of 0..STEP bits.
// Reports the last bit moved out of the word for the carry path.
module iter_shift_unit_step
    import iter_shift_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SW    = 1
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] work,
    input  logic [SW-1:0]    s,
    output logic [WIDTH-1:0] shifted,
    output logic             out_bit
);

    localparam logic [WIDTH-1:0] LSB_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

    logic [SW-1:0] s_m1;
    logic          lsb_out;
    logic          msb_out;

    // s_m1 wraps when s is 0; both taps are gated off in that case
    always_comb begin
        s_m1    = s - SW'(1);
        lsb_out = (s != '0) && (|(work & (LSB_ONE << s_m1)));
        msb_out = (s != '0) && (|(work & (MSB_ONE >> s_m1)));
    end

    always_comb begin
        shifted = work;
        out_bit = 1'b0;
        case (op)
            OP_SHR: begin
                shifted = work >> s;
                out_bit = lsb_out;
            end
            OP_SHRA: begin
                shifted = $unsigned($signed(work) >>> s);
                out_bit = lsb_out;
            end
            OP_SHL: begin
                shifted = work << s;
                out_bit = msb_out;
            end
            OP_ROR: begin
                shifted = (work >> s) | (work << (WIDTH - int'(s)));
                out_bit = lsb_out;
            end
            OP_ROL: begin
                shifted = (work << s) | (work >> (WIDTH - int'(s)));
                out_bit = msb_out;
            end
            default: begin
                shifted = work;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate unit: up to STEP bits per clock, finished pulse on done.
// Optional carry_out port enabled by defining SHIFT_CARRY_EN.
module iter_shift_unit
    import iter_shift_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] amount,
    output logic             busy,
    output logic             finished,
    output logic [WIDTH-1:0] result
`ifdef SHIFT_CARRY_EN
    ,
    output logic             carry_out
`endif
);

    localparam int AMTW = $clog2(WIDTH);
    localparam int SW   = $clog2(STEP + 1);
    localparam logic [AMTW:0] STEP_C = (AMTW + 1)'(STEP);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AMTW-1:0]  cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             finished_q, finished_d;

    logic             last_step;
    logic [SW-1:0]    step_s;
    logic [WIDTH-1:0] step_work;
    logic             step_bit;

    logic [WIDTH-AMTW-1:0] amount_unused;
    assign amount_unused = amount[WIDTH-1:AMTW];

    // The final edge shifts whatever remains, which may be fewer than STEP bits
    always_comb begin
        last_step = {1'b0, cnt_q} <= STEP_C;
        step_s    = last_step ? SW'(cnt_q) : SW'(STEP);
    end

    iter_shift_unit_step #(
        .WIDTH (WIDTH),
        .SW    (SW)
    ) u_step (
        .op      (op_q),
        .work    (work_q),
        .s       (step_s),
        .shifted (step_work),
        .out_bit (step_bit)
    );

`ifdef SHIFT_CARRY_EN
    logic carry_q, carry_d;
    assign carry_out = carry_q;
`else
    logic step_bit_unused;
    assign step_bit_unused = step_bit;
`endif

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        result_d   = result_q;
        busy_d     = busy_q;
        finished_d = 1'b0;
`ifdef SHIFT_CARRY_EN
        carry_d    = carry_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // The finished cycle still counts as busy for new requests
                if (start && !finished_q) begin
                    work_d  = operand;
                    cnt_d   = is_shift_op(op) ? amount[AMTW-1:0] : '0;
                    op_d    = op;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                work_d = step_work;
                if (last_step) begin
                    cnt_d      = '0;
                    result_d   = step_work;
                    finished_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
`ifdef SHIFT_CARRY_EN
                    carry_d    = step_bit;
`endif
                end else begin
                    cnt_d = cnt_q - AMTW'(step_s);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q    <= ST_IDLE;
            work_q     <= '0;
            cnt_q      <= '0;
            op_q       <= OP_PASS;
            result_q   <= '0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
        end
    end

`ifdef SHIFT_CARRY_EN
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end
`endif

    assign busy     = busy_q;
    assign finished = finished_q;
    assign result   = result_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Bench for iter_shift_unit: STEP=1 and STEP=4 instances, vector table,
// randomized ops against a one-shot arithmetic model, and control corner cases.
module tb_iter_shift_unit;

    localparam int W = 32;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    logic         start    [2];
    logic [2:0]   op       [2];
    logic [W-1:0] operand  [2];
    logic [W-1:0] amount   [2];
    logic         busy     [2];
    logic         finished [2];
    logic [W-1:0] result   [2];
    logic         carry    [2];

    int steps [2] = '{1, 4};

    int n_vec = 0;
    int n_err = 0;

    iter_shift_unit #(.WIDTH(W), .STEP(1)) u_s1 (
        .Clock    (clk),
        .clear    (clear),
        .start    (start[0]),
        .op       (op[0]),
        .operand  (operand[0]),
        .amount   (amount[0]),
        .busy     (busy[0]),
        .finished (finished[0]),
        .result   (result[0])
`ifdef SHIFT_CARRY_EN
        ,
        .carry_out(carry[0])
`endif
    );

    iter_shift_unit #(.WIDTH(W), .STEP(4)) u_s4 (
        .Clock    (clk),
        .clear    (clear),
        .start    (start[1]),
        .op       (op[1]),
        .operand  (operand[1]),
        .amount   (amount[1]),
        .busy     (busy[1]),
        .finished (finished[1]),
        .result   (result[1])
`ifdef SHIFT_CARRY_EN
        ,
        .carry_out(carry[1])
`endif
    );

`ifndef SHIFT_CARRY_EN
    assign carry[0] = 1'b0;
    assign carry[1] = 1'b0;
`endif

    typedef struct {
        int          d;
        logic [2:0]  op;
        logic [31:0] x;
        logic [31:0] amt;
        logic [31:0] res;
        int          lat;
        logic        c;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Single-shot reference: whole shift at once, carry = last bit moved out
    function automatic logic [32:0] model(input logic [2:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] amt);
        int          a;
        logic [63:0] dbl;
        logic [63:0] t;
        logic [31:0] r;
        logic        c;
        a   = int'(amt[4:0]);
        dbl = {x, x};
        r   = x;
        c   = 1'b0;
        case (o)
            3'd0: begin r = x >> a; if (a != 0) c = x[a-1]; end
            3'd1: begin r = $unsigned($signed(x) >>> a); if (a != 0) c = x[a-1]; end
            3'd2: begin r = x << a; if (a != 0) c = x[32-a]; end
            3'd3: begin t = dbl >> a; r = t[31:0]; if (a != 0) c = x[a-1]; end
            3'd4: begin t = dbl << a; r = t[63:32]; if (a != 0) c = x[32-a]; end
            default: begin r = x; c = 1'b0; end
        endcase
        return {c, r};
    endfunction

    function automatic int model_lat(input int st, input logic [2:0] o,
                                     input logic [31:0] amt);
        int a;
        a = int'(amt[4:0]);
        if (o > 3'd4 || a == 0) return 1;
        return (a + st - 1) / st;
    endfunction

    task automatic run_op(input int d, input logic [2:0] o,
                          input logic [31:0] x, input logic [31:0] amt,
                          input logic [31:0] er, input int el,
                          input logic ec, input string tag);
        logic [31:0] prev;
        int          cyc;
        bit          done;
        @(negedge clk);
        if (finished[d]) @(negedge clk);
        prev       = result[d];
        start[d]   = 1'b1;
        op[d]      = o;
        operand[d] = x;
        amount[d]  = amt;
        @(posedge clk);
        #1;
        start[d]   = 1'b0;
        op[d]      = 3'($urandom);
        operand[d] = $urandom;
        amount[d]  = $urandom;
        chk({tag, " busy_on_accept"}, 32'(busy[d]), 32'd1);
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (finished[d]) begin
                done = 1'b1;
            end else begin
                chk({tag, " result_hold"}, result[d], prev);
                chk({tag, " busy_mid"}, 32'(busy[d]), 32'd1);
            end
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: no finished within 100 cycles", tag);
        end else begin
            chk({tag, " latency"}, 32'(cyc), 32'(el));
            chk({tag, " result"}, result[d], er);
            chk({tag, " busy_at_finish"}, 32'(busy[d]), 32'd0);
`ifdef SHIFT_CARRY_EN
            chk({tag, " carry"}, 32'(carry[d]), 32'(ec));
`endif
        end
    endtask

    initial begin
        logic [32:0] m;
        int          pulses;
        int          d;
        bit          got;
        logic [2:0]  ro;
        logic [31:0] rx;
        logic [31:0] ra;

        tbl[0] = '{0, 3'd0, 32'h18,       32'd2,  32'h6,        2, 1'b0};
        tbl[1] = '{0, 3'd1, 32'h80000000, 32'd4,  32'hF8000000, 4, 1'b0};
        tbl[2] = '{0, 3'd4, 32'h80000001, 32'd1,  32'h3,        1, 1'b1};
        tbl[3] = '{0, 3'd2, 32'h1234,     32'h20, 32'h1234,     1, 1'b0};
        tbl[4] = '{1, 3'd2, 32'h1,        32'd31, 32'h80000000, 8, 1'b0};
        tbl[5] = '{1, 3'd3, 32'h1,        32'd1,  32'h80000000, 1, 1'b1};
        tbl[6] = '{0, 3'd7, 32'hDEADBEEF, 32'd5,  32'hDEADBEEF, 1, 1'b0};
        tbl[7] = '{1, 3'd0, 32'hF0,       32'd5,  32'h7,        2, 1'b1};
        tbl[8] = '{1, 3'd4, 32'h12345678, 32'd8,  32'h34567812, 2, 1'b0};

        for (int i = 0; i < 2; i++) begin
            start[i]   = 1'b0;
            op[i]      = 3'd0;
            operand[i] = '0;
            amount[i]  = '0;
        end

        clear = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset busy", 32'(busy[i]), 32'd0);
            chk("reset finished", 32'(finished[i]), 32'd0);
            chk("reset result", result[i], 32'd0);
        end
        repeat (2) @(negedge clk);
        clear = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].d, tbl[i].op, tbl[i].x, tbl[i].amt,
                   tbl[i].res, tbl[i].lat, tbl[i].c, $sformatf("tbl%0d", i));
        end

        // start held high through busy and the finished cycle
        @(negedge clk);
        if (finished[0]) @(negedge clk);
        start[0]   = 1'b1;
        op[0]      = 3'd0;
        operand[0] = 32'h80;
        amount[0]  = 32'd3;
        pulses     = 0;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            if (finished[0]) pulses++;
            if (e == 4) chk("hold finished_e4", 32'(finished[0]), 32'd1);
            if (e == 5) chk("hold busy_ignored", 32'(busy[0]), 32'd0);
            if (e == 6) chk("hold busy_reaccept", 32'(busy[0]), 32'd1);
        end
        start[0] = 1'b0;
        chk("hold single_pulse", 32'(pulses), 32'd1);
        chk("hold result", result[0], 32'h10);
        got = 1'b0;
        for (int e = 0; e < 10 && !got; e++) begin
            @(posedge clk);
            #1;
            if (finished[0]) begin
                got = 1'b1;
                chk("hold second_latency", 32'(e + 1), 32'd3);
                chk("hold second_result", result[0], 32'h10);
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL hold second: no finished within 10 cycles");
        end

        // clear asserted in the middle of a long shift
        @(negedge clk);
        if (finished[1]) @(negedge clk);
        start[1]   = 1'b1;
        op[1]      = 3'd2;
        operand[1] = 32'h1;
        amount[1]  = 32'd31;
        @(posedge clk);
        #1;
        start[1] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("clear busy", 32'(busy[1]), 32'd0);
        chk("clear finished", 32'(finished[1]), 32'd0);
        chk("clear result", result[1], 32'd0);
        chk("clear result_other", result[0], 32'd0);
`ifdef SHIFT_CARRY_EN
        chk("clear carry", 32'(carry[1]), 32'd0);
`endif
        @(negedge clk);
        clear  = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (finished[1]) pulses++;
        end
        chk("clear no_finished", 32'(pulses), 32'd0);
        run_op(1, 3'd3, 32'h1, 32'd1, 32'h80000000, 1, 1'b1, "post_clear");

        for (int i = 0; i < 60; i++) begin
            d  = int'($urandom_range(0, 1));
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ra = $urandom;
            if (i % 2 == 0) ra = ra & 32'h7;
            m  = model(ro, rx, ra);
            run_op(d, ro, rx, ra, m[31:0], model_lat(steps[d], ro, ra),
                   m[32], $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
